// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//
// Runs the per-frame game-logic update sequence. Every FRAME_DIV accepted
// frame_end pulses it starts NUM_STAGES logic units one after another
// (player, enemies, collision, score, ...). Each stage waits for its own done,
// or for a TIMEOUT-cycle watchdog, so a sequence always completes.
//
// Start/done handshake: stage_start[i] is a one-cycle pulse issued from the
// START state. From the following cycle the scheduler sits in WAIT and samples
// only stage_done[i]; any cycle in which that bit is high (pulse or level)
// completes the stage. Done is never sampled in START, so a done level left
// over from an earlier stage cannot complete the next one early.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   frame_end    in   one-cycle end-of-visible-frame pulse from sync generator
//   enable       in   gates acceptance of new frame_end pulses
//   stage_done   in   [NUM_STAGES] per-stage completion
//   stage_start  out  [NUM_STAGES] one-hot one-cycle start pulse
//   active_stage out  [SW] stage currently started/awaited, 0 when idle
//   busy         out  high whenever a sequence is in progress
//   update_done  out  one-cycle pulse when every stage of a frame is complete
//   frame_count  out  [8] completed sequences, wraps 255 -> 0
//   timeout_err  out  one-cycle pulse after a stage's watchdog expired
//   overrun      out  one-cycle pulse after a frame_end arrived while busy
//   overrun_flag out  sticky overrun, cleared only by reset
// -----------------------------------------------------------------------------
module frame_scheduler #(
   parameter int NUM_STAGES = 4,
   parameter int TIMEOUT    = 2048,
   parameter int FRAME_DIV  = 1,
   localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
   localparam int TW = $clog2(TIMEOUT) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_end,
   input  logic                  enable,
   input  logic [NUM_STAGES-1:0] stage_done,
   output logic [NUM_STAGES-1:0] stage_start,
   output logic [SW-1:0]         active_stage,
   output logic                  busy,
   output logic                  update_done,
   output logic [7:0]            frame_count,
   output logic                  timeout_err,
   output logic                  overrun,
   output logic                  overrun_flag
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      WAIT   = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic [7:0]    DIV_LAST   = 8'(FRAME_DIV - 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_STAGES - 1);

   state_t        state;
   logic [SW-1:0] stage;
   logic [7:0]    div;
   logic [TW-1:0] timer;
   logic          cur_done;

   assign cur_done = stage_done[stage];

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         stage        <= '0;
         div          <= '0;
         timer        <= '0;
         frame_count  <= '0;
         timeout_err  <= 1'b0;
         overrun      <= 1'b0;
         overrun_flag <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         overrun     <= 1'b0;

         // A frame_end that arrives mid-sequence (FINISH included) is dropped,
         // flagged, and leaves the divider untouched.
         if (state != IDLE && frame_end && enable) begin
            overrun      <= 1'b1;
            overrun_flag <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (frame_end && enable) begin
                  if (div == DIV_LAST) begin
                     div   <= '0;
                     stage <= '0;
                     state <= START;
                  end else begin
                     div <= div + 8'd1;
                  end
               end
            end

            START: begin
               timer <= '0;
               state <= WAIT;
            end

            WAIT: begin
               // Watchdog expiry advances exactly like a done; a real done in
               // the same cycle takes priority and suppresses the error.
               if (cur_done || timer == TIMER_LAST) begin
                  if (!cur_done) begin
                     timeout_err <= 1'b1;
                  end
                  if (stage == STAGE_LAST) begin
                     state <= FINISH;
                  end else begin
                     stage <= stage + 1'b1;
                     state <= START;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            FINISH: begin
               frame_count <= frame_count + 8'd1;
               state       <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decoded purely from registered state.
   always_comb begin
      stage_start  = '0;
      active_stage = '0;
      if (state == START) begin
         stage_start[stage] = 1'b1;
      end
      if (state == START || state == WAIT) begin
         active_stage = stage;
      end
   end

   assign busy        = (state != IDLE);
   assign update_done = (state == FINISH);

endmodule

// File: tb/tb_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_scheduler
//
// Two instances: dut (4 stages, TIMEOUT=16, FRAME_DIV=1) carries the main
// scenarios; dut_d (FRAME_DIV=3, stage_done tied high) exercises the divider.
// Cycle numbering: cyc increments at every posedge; "cycle n" is the period
// after posedge n. Inputs are driven #1 after a posedge (or at a negedge),
// outputs are sampled at the negedge.
// Every output event (any start, update_done, timeout_err or overrun) of dut is
// packed with its cycle and frame_count and compared against exp_q.
// -----------------------------------------------------------------------------
module tb_frame_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_end = 1'b0;
   logic       enable = 1'b1;
   logic [3:0] stage_done = 4'h0;
   logic [3:0] stage_start;
   logic [1:0] active_stage;
   logic       busy, update_done, timeout_err, overrun, overrun_flag;
   logic [7:0] frame_count;

   logic       frame_end_d = 1'b0;
   logic       enable_d = 1'b1;
   logic [3:0] stage_done_d = 4'hF;
   logic [3:0] stage_start_d;
   logic [1:0] active_stage_d;
   logic       busy_d, update_done_d, timeout_err_d, overrun_d, overrun_flag_d;
   logic [7:0] frame_count_d;

   frame_scheduler #(.NUM_STAGES(4), .TIMEOUT(16), .FRAME_DIV(1)) dut (
      .clk(clk), .reset(reset), .frame_end(frame_end), .enable(enable),
      .stage_done(stage_done), .stage_start(stage_start),
      .active_stage(active_stage), .busy(busy), .update_done(update_done),
      .frame_count(frame_count), .timeout_err(timeout_err),
      .overrun(overrun), .overrun_flag(overrun_flag)
   );

   frame_scheduler #(.NUM_STAGES(4), .TIMEOUT(16), .FRAME_DIV(3)) dut_d (
      .clk(clk), .reset(reset), .frame_end(frame_end_d), .enable(enable_d),
      .stage_done(stage_done_d), .stage_start(stage_start_d),
      .active_stage(active_stage_d), .busy(busy_d), .update_done(update_done_d),
      .frame_count(frame_count_d), .timeout_err(timeout_err_d),
      .overrun(overrun_d), .overrun_flag(overrun_flag_d)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   int          exp_d_q[$];
   bit          mon_en = 1'b0;
   logic [31:0] mon_act, mon_exp;
   int          mon_d_exp;

   function automatic logic [31:0] ev(input int c, input logic [3:0] st,
                                      input logic ud, input logic te,
                                      input logic ov, input logic [7:0] fc);
      logic [15:0] c16;
      c16 = c[15:0];
      return {c16, st, ud, te, ov, 1'b0, fc};
   endfunction

   // Event monitor for dut.
   always @(negedge clk) begin
      if (mon_en && (stage_start != 4'h0 || update_done || timeout_err || overrun)) begin
         mon_act = ev(cyc, stage_start, update_done, timeout_err, overrun, frame_count);
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event: actual=%h required=none (cycle %0d)", mon_act, cyc);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               failures++;
               $display("FAIL event: actual=%h required=%h (cycle %0d)", mon_act, mon_exp, cyc);
            end
         end
      end
   end

   // Sequence-start monitor for dut_d.
   always @(negedge clk) begin
      if (mon_en && stage_start_d[0]) begin
         checks++;
         if (exp_d_q.size() == 0) begin
            failures++;
            $display("FAIL div_start: actual=cycle %0d required=none", cyc);
         end else begin
            mon_d_exp = exp_d_q.pop_front();
            if (cyc != mon_d_exp) begin
               failures++;
               $display("FAIL div_start: actual=cycle %0d required=cycle %0d", cyc, mon_d_exp);
            end
         end
      end
   end

   // ---------------- stage responder ----------------
   // dly[i]: done asserted dly[i] cycles after stage_start[i] (0 = never).
   // hold[i]: force stage_done[i] high permanently.
   int dly[4] = '{2, 2, 2, 2};
   bit hold[4] = '{0, 0, 0, 0};
   int tgt[4] = '{-1, -1, -1, -1};

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         stage_done[i] = hold[i] || (cyc == tgt[i]);
         if (stage_start[i]) tgt[i] = (dly[i] == 0) ? -1 : cyc + dly[i];
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic to_cycle(input int t);
      while (cyc < t) step();
   endtask

   task automatic peek(input int t);
      to_cycle(t);
      @(negedge clk);
   endtask

   task automatic frame_at(input int t);
      to_cycle(t);
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
   endtask

   task automatic frame_d_at(input int t, input logic en);
      to_cycle(t);
      enable_d    = en;
      frame_end_d = 1'b1;
      step();
      frame_end_d = 1'b0;
      enable_d    = 1'b1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c;

      // Reset held over cycles 0..2, released in cycle 3.
      to_cycle(3);
      reset  = 1'b0;
      mon_en = 1'b1;
      peek(4);
      chk("rst_outputs", {stage_start, active_stage, update_done, timeout_err, overrun}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_count", frame_count, 0);
      chk("rst_overrun_flag", overrun_flag, 0);

      // Normal run: done 2 cycles after each start.
      dly = '{2, 2, 2, 2};
      exp_q.push_back(ev(11, 4'b0001, 0, 0, 0, 8'd0));
      exp_q.push_back(ev(14, 4'b0010, 0, 0, 0, 8'd0));
      exp_q.push_back(ev(17, 4'b0100, 0, 0, 0, 8'd0));
      exp_q.push_back(ev(20, 4'b1000, 0, 0, 0, 8'd0));
      exp_q.push_back(ev(23, 4'b0000, 1, 0, 0, 8'd0));
      frame_at(10);
      peek(15);
      chk("normal_active_wait1", active_stage, 1);
      chk("normal_busy_wait1", busy, 1);
      peek(23);
      chk("normal_active_finish", active_stage, 0);
      chk("normal_busy_finish", busy, 1);
      peek(24);
      chk("normal_frame_count", frame_count, 1);
      chk("normal_busy_after", busy, 0);

      // Timeout: stage 1 never answers.
      dly = '{2, 0, 2, 2};
      exp_q.push_back(ev(41, 4'b0001, 0, 0, 0, 8'd1));
      exp_q.push_back(ev(44, 4'b0010, 0, 0, 0, 8'd1));
      exp_q.push_back(ev(61, 4'b0100, 0, 1, 0, 8'd1));
      exp_q.push_back(ev(64, 4'b1000, 0, 0, 0, 8'd1));
      exp_q.push_back(ev(67, 4'b0000, 1, 0, 0, 8'd1));
      frame_at(40);
      peek(68);
      chk("timeout_frame_count", frame_count, 2);

      // Done lands on the last watchdog cycle: advances, no timeout_err.
      dly = '{2, 16, 2, 2};
      exp_q.push_back(ev(81, 4'b0001, 0, 0, 0, 8'd2));
      exp_q.push_back(ev(84, 4'b0010, 0, 0, 0, 8'd2));
      exp_q.push_back(ev(101, 4'b0100, 0, 0, 0, 8'd2));
      exp_q.push_back(ev(104, 4'b1000, 0, 0, 0, 8'd2));
      exp_q.push_back(ev(107, 4'b0000, 1, 0, 0, 8'd2));
      frame_at(80);
      peek(108);
      chk("tie_frame_count", frame_count, 3);

      // Overrun while stage 2 is awaited, and again in the FINISH cycle.
      dly = '{2, 2, 2, 2};
      exp_q.push_back(ev(121, 4'b0001, 0, 0, 0, 8'd3));
      exp_q.push_back(ev(124, 4'b0010, 0, 0, 0, 8'd3));
      exp_q.push_back(ev(127, 4'b0100, 0, 0, 0, 8'd3));
      exp_q.push_back(ev(129, 4'b0000, 0, 0, 1, 8'd3));
      exp_q.push_back(ev(130, 4'b1000, 0, 0, 0, 8'd3));
      exp_q.push_back(ev(133, 4'b0000, 1, 0, 0, 8'd3));
      exp_q.push_back(ev(134, 4'b0000, 0, 0, 1, 8'd4));
      frame_at(120);
      frame_at(128);
      frame_at(133);
      peek(160);
      chk("overrun_flag_sticky", overrun_flag, 1);
      chk("overrun_idle_after", busy, 0);
      chk("overrun_frame_count", frame_count, 4);

      // enable=0: frame_end ignored.
      enable = 1'b0;
      frame_at(170);
      enable = 1'b1;
      peek(175);
      chk("disabled_busy", busy, 0);

      // Stage 0 done held high; enable dropped mid-sequence.
      hold[0] = 1'b1;
      exp_q.push_back(ev(191, 4'b0001, 0, 0, 0, 8'd4));
      exp_q.push_back(ev(193, 4'b0010, 0, 0, 0, 8'd4));
      exp_q.push_back(ev(196, 4'b0100, 0, 0, 0, 8'd4));
      exp_q.push_back(ev(199, 4'b1000, 0, 0, 0, 8'd4));
      exp_q.push_back(ev(202, 4'b0000, 1, 0, 0, 8'd4));
      frame_at(190);
      to_cycle(192);
      enable = 1'b0;
      peek(197);
      chk("stale_active_stage", active_stage, 2);
      peek(203);
      chk("stale_frame_count", frame_count, 5);
      hold[0] = 1'b0;
      enable  = 1'b1;

      // Reset while waiting on stage 2.
      dly = '{2, 2, 0, 2};
      exp_q.push_back(ev(221, 4'b0001, 0, 0, 0, 8'd5));
      exp_q.push_back(ev(224, 4'b0010, 0, 0, 0, 8'd5));
      exp_q.push_back(ev(227, 4'b0100, 0, 0, 0, 8'd5));
      frame_at(220);
      peek(229);
      chk("pre_reset_active", active_stage, 2);
      chk("pre_reset_busy", busy, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      peek(230);
      chk("midrst_outputs", {stage_start, active_stage, update_done, timeout_err, overrun}, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_frame_count", frame_count, 0);
      chk("midrst_overrun_flag", overrun_flag, 0);

      // Divider (FRAME_DIV=3) with one disabled pulse that must not count.
      exp_d_q.push_back(287);
      exp_d_q.push_back(323);
      frame_d_at(250, 1'b1);
      frame_d_at(262, 1'b1);
      frame_d_at(274, 1'b0);
      peek(280);
      chk("div_idle_after_disabled", busy_d, 0);
      frame_d_at(286, 1'b1);
      peek(288);
      chk("div_busy_seq1", busy_d, 1);
      frame_d_at(298, 1'b1);
      frame_d_at(310, 1'b1);
      frame_d_at(322, 1'b1);
      peek(340);
      chk("div_frame_count", frame_count_d, 2);

      // 256 back-to-back minimum-length sequences: frame_count wraps to 0.
      dly = '{1, 1, 1, 1};
      for (int k = 0; k < 256; k++) begin
         c = 360 + 10 * k;
         exp_q.push_back(ev(c + 1, 4'b0001, 0, 0, 0, 8'(k)));
         exp_q.push_back(ev(c + 3, 4'b0010, 0, 0, 0, 8'(k)));
         exp_q.push_back(ev(c + 5, 4'b0100, 0, 0, 0, 8'(k)));
         exp_q.push_back(ev(c + 7, 4'b1000, 0, 0, 0, 8'(k)));
         exp_q.push_back(ev(c + 9, 4'b0000, 1, 0, 0, 8'(k)));
         frame_at(c);
      end
      peek(2925);
      chk("wrap_frame_count", frame_count, 0);
      chk("wrap_overrun_flag", overrun_flag, 0);

      chk("exp_q_drained", exp_q.size(), 0);
      chk("exp_d_q_drained", exp_d_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
